// File: rtl/offchip_mem_pkg.sv
// offchip_mem_pkg: shared latency defaults, channel states and address/mask helpers
package offchip_mem_pkg;
  localparam int RD_LAT_DEF = 2;
  localparam int WR_LAT_DEF = 1;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} ch_state_e;
  function automatic logic [63:0] wmask(input int unsigned size, input int unsigned dw);
    return (64'd1 << (size < dw ? size : dw)) - 64'd1;
  endfunction
  function automatic logic in_window(input longint unsigned a, input longint unsigned base,
                                     input longint unsigned depth);
    return a >= base && a < base + depth;
  endfunction
endpackage

// File: rtl/mem_channel_port.sv
// mem_channel_port: per-channel latency counter, read pipeline and completion handshake
module mem_channel_port
  import offchip_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int WR_LAT = WR_LAT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              oe,
  input  logic              we,
  input  logic              in_win,
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] sout_rdata,
  input  logic              sout_rdy,
  output logic [DATA_W-1:0] rdata,
  output logic              data_rdy,
  output logic              wr_commit,
  output logic              err_conflict,
  output logic              err_oob
);
  localparam int MAXL = RD_LAT > WR_LAT ? RD_LAT : WR_LAT;
  localparam int CW = MAXL > 1 ? $clog2(MAXL) : 1;
  ch_state_e st, st_n;
  logic [CW-1:0] cnt, cnt_n, c0;
  logic rd, wr, rd_done, wr_done;
  logic [DATA_W-1:0] model;
  // counter only carries over while the same kind of request stays asserted
  always_comb begin
    rd = oe & ~we & in_win;
    wr = we & ~oe & in_win;
    c0 = ((st == RD_WAIT && rd) || (st == WR_WAIT && wr)) ? cnt : '0;
    rd_done = rd && c0 == CW'(RD_LAT - 1);
    wr_done = wr && c0 == CW'(WR_LAT - 1);
    st_n = (rd && !rd_done) ? RD_WAIT : (wr && !wr_done) ? WR_WAIT : IDLE;
    cnt_n = st_n == IDLE ? '0 : c0 + CW'(1);
    data_rdy = (reset & (rd_done | wr_done)) | sout_rdy;
    rdata = ((reset & rd_done) ? model : '0) | sout_rdata;
    wr_commit = reset & wr_done;
    err_oob = reset & (oe | we) & ~in_win;
  end
  // state, counter and sticky conflict flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      cnt <= '0;
      err_conflict <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      err_conflict <= err_conflict | (oe & we);
    end
  end
  if (RD_LAT == 1) begin : g_comb
    assign model = rd_word;
  end else begin : g_pipe
    logic [DATA_W-1:0] pipe [RD_LAT-1];
    // word sampled in the first read cycle walks to the last stage by completion
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < RD_LAT - 1; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= (rd && c0 == '0) ? rd_word : '0;
        for (int k = 1; k < RD_LAT - 1; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign model = pipe[RD_LAT-2];
  end
endmodule

// File: rtl/offchip_mem_model.sv
// offchip_mem_model: multi-channel latency-accurate memory window with backdoor preload
module offchip_mem_model
  import offchip_mem_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int SIZE_W    = 4,
  parameter int DEPTH     = 1,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int WR_LAT    = WR_LAT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NCH-1:0]        Mout_oe_ram,
  input  logic [NCH-1:0]        Mout_we_ram,
  input  logic [NCH*ADDR_W-1:0] Mout_addr_ram,
  input  logic [NCH*DATA_W-1:0] Mout_Wdata_ram,
  input  logic [NCH*SIZE_W-1:0] Mout_data_ram_size,
  input  logic [NCH*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [NCH-1:0]        Sout_DataRdy,
  input  logic                  load_en,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [DATA_W-1:0]     load_data,
  output logic [NCH*DATA_W-1:0] M_Rdata_ram,
  output logic [NCH-1:0]        M_DataRdy,
  output logic [NCH-1:0]        err_conflict,
  output logic [NCH-1:0]        err_oob
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [2**IW];
  logic [DATA_W-1:0] rd_word [NCH];
  logic [DATA_W-1:0] wm [NCH];
  logic [IW-1:0] idx [NCH];
  logic [NCH-1:0] win, commit;
  logic load_ok;
  assign load_ok = 32'(load_addr) < 32'(DEPTH);
  genvar i;
  for (i = 0; i < NCH; i++) begin : g_ch
    logic [ADDR_W-1:0] a;
    assign a = Mout_addr_ram[i*ADDR_W +: ADDR_W];
    assign win[i] = in_window(64'(a), 64'(BASE_ADDR), 64'(DEPTH));
    assign idx[i] = IW'(a - ADDR_W'(BASE_ADDR));
    assign rd_word[i] = win[i] ? mem[idx[i]] : '0;
    assign wm[i] = DATA_W'(wmask(32'(Mout_data_ram_size[i*SIZE_W +: SIZE_W]), 32'(DATA_W)));
    mem_channel_port #(.DATA_W(DATA_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) u_port (
      .clock       (clock),
      .reset       (reset),
      .oe          (Mout_oe_ram[i]),
      .we          (Mout_we_ram[i]),
      .in_win      (win[i]),
      .rd_word     (rd_word[i]),
      .sout_rdata  (Sout_Rdata_ram[i*DATA_W +: DATA_W]),
      .sout_rdy    (Sout_DataRdy[i]),
      .rdata       (M_Rdata_ram[i*DATA_W +: DATA_W]),
      .data_rdy    (M_DataRdy[i]),
      .wr_commit   (commit[i]),
      .err_conflict(err_conflict[i]),
      .err_oob     (err_oob[i])
    );
  end
  // storage survives reset; later channels overwrite earlier ones, preload overrides all
  always_ff @(posedge clock) begin
    for (int k = 0; k < NCH; k++)
      if (commit[k]) mem[idx[k]] <= (mem[idx[k]] & ~wm[k]) | (Mout_Wdata_ram[k*DATA_W +: DATA_W] & wm[k]);
    if (load_en && load_ok) mem[IW'(load_addr)] <= load_data;
  end
endmodule

// File: tb/tb_offchip_mem_model.sv
// tb_offchip_mem_model: randomized scoreboard bench for offchip_mem_model
module tb_offchip_mem_model;
  localparam int NCH = 2, ADDR_W = 7, DATA_W = 8, SIZE_W = 4, DEPTH = 4, BASE = 16;
  localparam int RD_LAT = 2, WR_LAT = 1;
  localparam int OP_ID = 0, OP_RD = 1, OP_WR = 2, OP_AB = 3, OP_CF = 4;
  typedef struct {
    int         cyc;
    logic       rd;
    logic [7:0] data;
  } exp_t;

  logic clock = 0, reset = 0;
  logic [NCH-1:0] Mout_oe_ram = '0, Mout_we_ram = '0, Sout_DataRdy = '0;
  logic [NCH*ADDR_W-1:0] Mout_addr_ram = '0;
  logic [NCH*DATA_W-1:0] Mout_Wdata_ram = '0, Sout_Rdata_ram = '0;
  logic [NCH*SIZE_W-1:0] Mout_data_ram_size = '0;
  logic load_en = 0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic [NCH*DATA_W-1:0] M_Rdata_ram;
  logic [NCH-1:0] M_DataRdy, err_conflict, err_oob;

  exp_t q [NCH][$];
  logic [7:0] ref_mem [DEPTH];
  logic [NCH-1:0] exp_conf;
  int cyc = 0, tests = 0, fails = 0;
  int s_op [NCH];
  logic [6:0] s_addr [NCH];
  logic [7:0] s_wd [NCH];
  logic [3:0] s_sz [NCH];
  logic s_ld;
  logic [6:0] s_la;
  logic [7:0] s_ldd;
  logic m_hit;
  logic [7:0] m_data;

  offchip_mem_model #(
    .NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram),
    .Mout_addr_ram(Mout_addr_ram), .Mout_Wdata_ram(Mout_Wdata_ram),
    .Mout_data_ram_size(Mout_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
    .err_conflict(err_conflict), .err_oob(err_oob)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock or negedge reset) exp_conf <= !reset ? '0 : exp_conf | (Mout_oe_ram & Mout_we_ram);

  function automatic logic in_win(input logic [6:0] a);
    return int'(a) >= BASE && int'(a) < BASE + DEPTH;
  endfunction

  function automatic logic [7:0] mask_of(input int sz);
    return sz >= 8 ? 8'hFF : 8'((1 << sz) - 1);
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s ch%0d cyc %0d: got %0h expected %0h", name, c, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    for (int c = 0; c < NCH; c++) begin
      m_hit = q[c].size() > 0 && q[c][0].cyc == cyc;
      m_data = (m_hit && q[c][0].rd) ? q[c][0].data : 8'h00;
      check("data_rdy", c, 32'(M_DataRdy[c]), 32'(m_hit | Sout_DataRdy[c]));
      check("rdata", c, 32'(M_Rdata_ram[c*8 +: 8]), 32'(m_data | Sout_Rdata_ram[c*8 +: 8]));
      check("err_oob", c, 32'(err_oob[c]),
            32'(reset & (Mout_oe_ram[c] | Mout_we_ram[c]) & ~in_win(Mout_addr_ram[c*7 +: 7])));
      check("err_conflict", c, 32'(err_conflict[c]), 32'(exp_conf[c]));
      if (m_hit) void'(q[c].pop_front());
    end
  end

  task automatic idle_all();
    for (int c = 0; c < NCH; c++) s_op[c] = OP_ID;
    s_ld = 0;
  endtask

  task automatic chan(input int c, input int op, input int a, input logic [7:0] d, input int sz);
    s_op[c] = op;
    s_addr[c] = 7'(a);
    s_wd[c] = d;
    s_sz[c] = 4'(sz);
  endtask

  task automatic do_step();
    logic [7:0] pre [DEPTH];
    int wi;
    @(posedge clock); #1;
    pre = ref_mem;
    for (int c = 0; c < NCH; c++) begin
      Mout_addr_ram[c*ADDR_W +: ADDR_W] = s_addr[c];
      Mout_Wdata_ram[c*DATA_W +: DATA_W] = s_wd[c];
      Mout_data_ram_size[c*SIZE_W +: SIZE_W] = s_sz[c];
      Mout_oe_ram[c] = s_op[c] == OP_RD || s_op[c] == OP_AB || s_op[c] == OP_CF;
      Mout_we_ram[c] = s_op[c] == OP_WR || s_op[c] == OP_CF;
      wi = int'(s_addr[c]) - BASE;
      if (in_win(s_addr[c]) && s_op[c] == OP_RD) q[c].push_back('{cyc + RD_LAT - 1, 1'b1, pre[wi]});
      if (in_win(s_addr[c]) && s_op[c] == OP_WR) begin
        q[c].push_back('{cyc + WR_LAT - 1, 1'b0, 8'h00});
        ref_mem[wi] = (pre[wi] & ~mask_of(int'(s_sz[c]))) | (s_wd[c] & mask_of(int'(s_sz[c])));
      end
    end
    load_en = s_ld;
    load_addr = s_la;
    load_data = s_ldd;
    if (s_ld && int'(s_la) < DEPTH) ref_mem[int'(s_la)] = s_ldd;
    for (int k = 1; k < RD_LAT; k++) begin
      @(posedge clock); #1;
      load_en = 0;
      for (int c = 0; c < NCH; c++) begin
        if (s_op[c] == OP_AB) Mout_oe_ram[c] = 0;
        if (s_op[c] == OP_WR && k >= WR_LAT) Mout_we_ram[c] = 0;
      end
    end
  endtask

  task automatic load(input int a, input logic [7:0] d);
    idle_all();
    s_ld = 1;
    s_la = 7'(a);
    s_ldd = d;
    do_step();
  endtask

  task automatic read_all();
    for (int w = 0; w < DEPTH; w++) begin
      idle_all();
      chan(w % NCH, OP_RD, BASE + w, 8'h00, 0);
      do_step();
    end
  endtask

  initial begin
    int r;
    s_la = '0;
    s_ldd = '0;
    for (int c = 0; c < NCH; c++) chan(c, OP_ID, 0, 8'h00, 0);
    idle_all();
    Sout_DataRdy = 2'b01;
    Sout_Rdata_ram = 16'hA500;
    repeat (3) @(posedge clock);
    #1;
    Sout_DataRdy = '0;
    Sout_Rdata_ram = '0;
    reset = 1;
    for (int w = 0; w < DEPTH; w++) load(w, 8'($urandom));
    load(DEPTH, 8'hEE);
    read_all();
    load(0, 8'h5A);
    idle_all(); chan(0, OP_RD, BASE, 8'h00, 0); do_step();
    idle_all(); chan(1, OP_WR, BASE, 8'hFF, 4); do_step();
    idle_all(); chan(0, OP_RD, BASE, 8'h00, 0); do_step();
    idle_all(); chan(0, OP_CF, BASE, 8'h00, 8); do_step();
    idle_all(); chan(1, OP_RD, BASE, 8'h00, 0); do_step();
    Sout_DataRdy = 2'b01;
    idle_all(); chan(0, OP_RD, 0, 8'h00, 0); do_step();
    Sout_DataRdy = '0;
    idle_all(); chan(0, OP_WR, BASE, 8'h11, 8); chan(1, OP_WR, BASE, 8'h22, 8); do_step();
    idle_all(); chan(0, OP_RD, BASE + 1, 8'h00, 0); chan(1, OP_WR, BASE + 1, 8'hC3, 8); do_step();
    idle_all(); chan(1, OP_WR, BASE + 2, 8'h99, 8); s_ld = 1; s_la = 7'd2; s_ldd = 8'h3C; do_step();
    idle_all(); chan(0, OP_AB, BASE + 1, 8'h00, 0); do_step();
    read_all();
    @(posedge clock); #1;
    Mout_we_ram = '0;
    Mout_oe_ram = 2'b01;
    Mout_addr_ram[6:0] = 7'(BASE + 1);
    @(negedge clock); #1;
    reset = 0;
    Mout_oe_ram = '0;
    @(posedge clock); #1;
    reset = 1;
    idle_all(); do_step();
    read_all();
    repeat (400) begin
      idle_all();
      for (int c = 0; c < NCH; c++) begin
        r = int'($urandom_range(0, 19));
        chan(c, r < 3 ? OP_ID : r < 9 ? OP_RD : r < 15 ? OP_WR : r < 19 ? OP_AB : OP_CF,
             $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 127)) : BASE + int'($urandom_range(0, DEPTH - 1)),
             8'($urandom), int'($urandom_range(0, 15)));
      end
      s_ld = $urandom_range(0, 9) == 0;
      s_la = 7'($urandom_range(0, DEPTH + 1));
      s_ldd = 8'($urandom);
      do_step();
    end
    read_all();
    idle_all(); do_step(); do_step();
    for (int c = 0; c < NCH; c++) check("drain", c, 32'(q[c].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/offchip_mem_model.md
OFFCHIP_MEM_MODEL -- requirements
Module: offchip_mem_model

Interface
REQ-001 Parameters SHALL be: NCH, default 2, number of memory channels.
REQ-002 ADDR_W, default 7, per-channel byte-address width.
REQ-003 DATA_W, default 8, per-channel data width; SIZE_W, default 4, per-channel size-field width.
REQ-004 DEPTH, default 1, number of DATA_W words modelled; BASE_ADDR, default 0, first modelled address.
REQ-005 RD_LAT, default 2, read latency, >=1; WR_LAT, default 1, write latency, >=1.
REQ-006 Ports SHALL be:
- clock  in  1  sole clock, all state changes on rising edge;
- reset  in  1  asynchronous, active-low;
- Mout_oe_ram  in  NCH  per-channel read enable;
- Mout_we_ram  in  NCH  per-channel write enable;
- Mout_addr_ram  in  NCH*ADDR_W  per-channel address;
- Mout_Wdata_ram  in  NCH*DATA_W  per-channel write data;
- Mout_data_ram_size  in  NCH*SIZE_W  per-channel access width in bits;
- Sout_Rdata_ram  in  NCH*DATA_W  slave read data, ORed into M_Rdata_ram;
- Sout_DataRdy  in  NCH  slave ready, ORed into M_DataRdy;
- load_en  in  1  backdoor preload strobe;
- load_addr  in  ADDR_W  backdoor word index, relative to BASE_ADDR;
- load_data  in  DATA_W  backdoor data;
- M_Rdata_ram  out  NCH*DATA_W  read data to master;
- M_DataRdy  out  NCH  per-channel completion;
- err_conflict  out  NCH  sticky: oe and we asserted together;
- err_oob  out  NCH  one-cycle pulse: access outside window.

Function
REQ-007 Channel c SHALL be in-window when BASE_ADDR <= addr_c < BASE_ADDR+DEPTH; word index = addr_c - BASE_ADDR.
REQ-008 Each channel SHALL hold an independent counter cnt_c; states IDLE (cnt=0, no request), RD_WAIT, WR_WAIT.
REQ-009 Read: with oe_c high and in-window, cnt_c SHALL increment each cycle; M_DataRdy[c] SHALL assert in the cycle cnt_c==RD_LAT-1, then cnt_c returns to 0.
REQ-010 Read data SHALL be the word sampled in the first oe cycle, delivered through an RD_LAT-1 stage pipeline (RD_LAT=1: combinational), zero when out-of-window.
REQ-011 Write: with we_c high and in-window, M_DataRdy[c] SHALL assert when cnt_c==WR_LAT-1; the word SHALL update at the rising edge ending that cycle.
REQ-012 Write mask SHALL be (1<<size_c)-1 truncated to DATA_W; size_c >= DATA_W yields a full mask; unmasked bits keep old value.
REQ-013 Dropping oe_c/we_c before completion SHALL return cnt_c to 0 with no data transfer.
REQ-014 oe_c and we_c both high SHALL set err_conflict[c], perform no access, clear cnt_c.
REQ-015 An oe or we out-of-window SHALL pulse err_oob[c] for that cycle, assert no model DataRdy, and return zero read data.
REQ-016 Same-word writes completing on two channels in one cycle: higher channel index SHALL win.
REQ-017 Read and write to one word in the same sample cycle: read SHALL return pre-write data.
REQ-018 load_en SHALL write load_data at the next edge with priority over channel writes; out-of-range load_addr ignored.

Reset
REQ-019 reset low SHALL immediately force cnt_c=0, read pipeline=0, M_DataRdy=Sout_DataRdy, M_Rdata_ram=Sout_Rdata_ram, err_conflict=0, err_oob=0.
REQ-020 Memory contents SHALL be unaffected by reset; an in-flight access aborted by reset SHALL not commit.

Structure
REQ-021 Latency defaults, mask-function and window-check helpers SHALL live in shared package offchip_mem_pkg.
REQ-022 Per-channel counter, pipeline and handshake SHALL be one sub-module mem_channel_port, instantiated NCH times; storage array shared in top.

Verification
REQ-023 NCH=2, RD_LAT=2, BASE_ADDR=0x10: preload 0x5A at word 0, oe ch0 addr 0x10 -> DataRdy[0] and Rdata 0x5A in cycle 1 only.
REQ-024 WR_LAT=1, size=4, we ch1 addr 0x10 data 0xFF over 0x5A -> DataRdy[1] in cycle 0, word becomes 0x5F.
REQ-025 oe and we both high on ch0 -> err_conflict[0]=1 held, word unchanged, no DataRdy.
REQ-026 oe ch0 addr 0x00 -> err_oob[0] one cycle, Rdata 0, DataRdy[0] follows Sout_DataRdy[0].
REQ-027 Both channels write word 0 same cycle (0x11 ch0, 0x22 ch1) -> word reads 0x22.
REQ-028 reset low in RD_WAIT cycle 0 -> no DataRdy after release, cnt=0, memory intact.
